// File: rtl/vram_writer.sv
// vram_writer: host-side write port into video RAM.
//   The block owns the VRAM byte array and serves the pixel processor's read
//   bus combinationally. Host commands enter through a valid/ready handshake
//   into a small FIFO. They are then applied in order to an auto-incrementing
//   address pointer.
// Ports:
//   clk, reset          - clock; asynchronous active-low reset
//   hpu_addr/hpu_data   - pixel-processor read bus (8'h00 beyond DEPTH)
//   host_valid/ready    - command handshake (ready == FIFO not full)
//   host_cmd/host_data  - 0 ADDR_LO, 1 ADDR_HI, 2 DATA, 3 INC, plus operand
//   wr_allow            - commits are permitted this cycle
//   busy                - FIFO non-empty (or readback in flight)
// Optional: define VRAM_WR_READBACK_EN to add host_rd_req / host_rd_valid /
//   host_rd_data, a one-byte readback at the pointer.
module vram_writer #(
  parameter int DEPTH      = 16384,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] hpu_addr,
  output logic [7:0]  hpu_data,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [1:0]  host_cmd,
  input  logic [7:0]  host_data,
  input  logic        wr_allow,
  output logic        busy
`ifdef VRAM_WR_READBACK_EN
  ,
  input  logic        host_rd_req,
  output logic        host_rd_valid,
  output logic [7:0]  host_rd_data
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [1:0] {CMD_ADDR_LO, CMD_ADDR_HI, CMD_DATA, CMD_INC} cmd_e;
`ifdef VRAM_WR_READBACK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_READ} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN} state_e;
`endif

  function automatic logic in_range(input logic [15:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  logic [7:0] mem  [DEPTH];
  logic [1:0] fcmd [FIFO_DEPTH];
  logic [7:0] fdat [FIFO_DEPTH];

  // FIFO pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]   wp_q, wp_d, rp_q, rp_d;
  logic [15:0]   ptr_q, ptr_d;
  logic [7:0]    inc_q, inc_d;
  state_e        state_q, state_d;
  logic          empty, full, push, pop;
  logic          mem_we;
  logic [1:0]    head_cmd;
  logic [7:0]    head_dat;
`ifdef VRAM_WR_READBACK_EN
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;
`endif

  assign empty      = (wp_q == rp_q);
  assign full       = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign host_ready = !full;
  assign head_cmd   = fcmd[rp_q[PW-1:0]];
  assign head_dat   = fdat[rp_q[PW-1:0]];
  assign hpu_data   = in_range(hpu_addr) ? mem[hpu_addr[AW-1:0]] : 8'h00;

`ifdef VRAM_WR_READBACK_EN
  assign busy          = !empty || (state_q == ST_READ);
  assign host_rd_valid = rd_valid_q;
  assign host_rd_data  = rd_data_q;
`else
  assign busy = !empty;
`endif

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    ptr_d   = ptr_q;
    inc_d   = inc_q;
    state_d = state_q;
    pop     = 1'b0;
    mem_we  = 1'b0;
`ifdef VRAM_WR_READBACK_EN
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
`endif
    push = host_valid && !full;
    if (push) wp_d = wp_q + (PW+1)'(1);

    case (state_q)
      ST_IDLE: begin
`ifdef VRAM_WR_READBACK_EN
        // IDLE implies an empty FIFO, so no queued command can be overtaken.
        if (host_rd_req) state_d = ST_READ;
`endif
      end
      ST_DRAIN: pop = wr_allow && !empty;
`ifdef VRAM_WR_READBACK_EN
      ST_READ: begin
        rd_valid_d = 1'b1;
        rd_data_d  = in_range(ptr_q) ? mem[ptr_q[AW-1:0]] : 8'h00;
        ptr_d      = ptr_q + {8'd0, inc_q};
        state_d    = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      rp_d = rp_q + (PW+1)'(1);
      case (cmd_e'(head_cmd))
        CMD_ADDR_LO: ptr_d[7:0]  = head_dat;
        CMD_ADDR_HI: ptr_d[15:8] = head_dat;
        CMD_DATA: begin
          mem_we = in_range(ptr_q) && reset;
          ptr_d  = ptr_q + {8'd0, inc_q};
        end
        default:     inc_d = head_dat;
      endcase
    end

    // Outside a readback, the state simply tracks FIFO occupancy after this edge,
    // so a push at edge N is poppable at edge N+1.
`ifdef VRAM_WR_READBACK_EN
    if (state_d != ST_READ)
`endif
      state_d = (wp_d != rp_d) ? ST_DRAIN : ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      ptr_q   <= 16'h0000;
      inc_q   <= 8'h01;
      state_q <= ST_IDLE;
`ifdef VRAM_WR_READBACK_EN
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
`endif
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      ptr_q   <= ptr_d;
      inc_q   <= inc_d;
      state_q <= state_d;
`ifdef VRAM_WR_READBACK_EN
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
`endif
    end
  end

  // Storage arrays are never cleared; the FIFO pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fcmd[wp_q[PW-1:0]] <= host_cmd;
      fdat[wp_q[PW-1:0]] <= host_data;
    end
    if (mem_we) mem[ptr_q[AW-1:0]] <= head_dat;
  end

endmodule

// File: tb/tb_vram_writer.sv
module tb_vram_writer;
  localparam int DEPTH = 16384;
  localparam int FD    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hpu_addr;
  logic [7:0]  hpu_data;
  logic        host_valid, host_ready, wr_allow, busy;
  logic [1:0]  host_cmd;
  logic [7:0]  host_data;
`ifdef VRAM_WR_READBACK_EN
  logic        host_rd_req, host_rd_valid;
  logic [7:0]  host_rd_data;
`endif

  vram_writer #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .hpu_addr(hpu_addr), .hpu_data(hpu_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
    .host_data(host_data), .wr_allow(wr_allow), .busy(busy)
`ifdef VRAM_WR_READBACK_EN
    , .host_rd_req(host_rd_req), .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [1:0] c; logic [7:0] d; } ent_t;
  ent_t        mq[$];
  logic [15:0] m_ptr;
  logic [7:0]  m_inc;
  logic [7:0]  m_mem   [0:65535];
  bit          m_known [0:65535];
  bit          m_reading, m_rv, m_rd_known;
  logic [7:0]  m_rd;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ptr = 16'h0; m_inc = 8'h1;
      m_reading = 0; m_rv = 0; m_rd = 8'h0; m_rd_known = 1;
    end else begin
      int sz0;
      bit rv;
      ent_t e;
      sz0 = mq.size();
      rv  = 0;
      if (m_reading) begin
        m_rd_known = (int'(m_ptr) >= DEPTH) || m_known[m_ptr];
        m_rd = (int'(m_ptr) >= DEPTH) ? 8'h00 : m_mem[m_ptr];
        m_ptr = m_ptr + 16'(m_inc);
        m_reading = 0;
        rv = 1;
      end else if (sz0 == 0) begin
`ifdef VRAM_WR_READBACK_EN
        if (host_rd_req) m_reading = 1;
`endif
      end else if (wr_allow) begin
        e = mq.pop_front();
        case (e.c)
          2'd0: m_ptr[7:0]  = e.d;
          2'd1: m_ptr[15:8] = e.d;
          2'd2: begin
            if (int'(m_ptr) < DEPTH) begin
              m_mem[m_ptr] = e.d;
              m_known[m_ptr] = 1;
            end
            m_ptr = m_ptr + 16'(m_inc);
          end
          default: m_inc = e.d;
        endcase
      end
      if (host_valid && sz0 < FD) mq.push_back('{host_cmd, host_data});
      m_rv = rv;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ready", host_ready, 32'(mq.size() < FD));
    chk("busy", busy, 32'(mq.size() != 0 || m_reading));
    if (int'(hpu_addr) >= DEPTH) chk("hpu_oob", hpu_data, 0);
    else if (m_known[hpu_addr]) chk("hpu_data", hpu_data, 32'(m_mem[hpu_addr]));
`ifdef VRAM_WR_READBACK_EN
    chk("rd_valid", host_rd_valid, 32'(m_rv));
    if (m_rd_known) chk("rd_data", host_rd_data, 32'(m_rd));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d);
    int n = 0;
    logic r;
    host_cmd = c; host_data = d; host_valid = 1'b1;
    do begin
      @(negedge clk); r = host_ready;
      @(posedge clk); #2; n++;
    end while (!r && n < 200);
    if (!r) chk("send_timeout", 1, 0);
    host_valid = 1'b0;
  endtask

  task automatic set_addr(input logic [15:0] a);
    send(2'd1, a[15:8]);
    send(2'd0, a[7:0]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin step(); n++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic peek(input string nm, input logic [15:0] a, input logic [7:0] exp);
    hpu_addr = a; #1;
    chk(nm, hpu_data, 32'(exp));
  endtask

`ifdef VRAM_WR_READBACK_EN
  task automatic readback(input string nm, input logic [7:0] exp);
    int n = 0;
    host_rd_req = 1'b1;
    while (!host_rd_valid && n < 100) begin step(); n++; end
    host_rd_req = 1'b0;
    if (!host_rd_valid) chk("rd_timeout", 1, 0);
    chk(nm, host_rd_data, 32'(exp));
  endtask
`endif

  initial begin
    reset = 1'b0; hpu_addr = 16'h0; host_valid = 0; host_cmd = 0; host_data = 0; wr_allow = 1;
`ifdef VRAM_WR_READBACK_EN
    host_rd_req = 0;
`endif
    step(); step();
    chk("rst_ready", host_ready, 1);
    chk("rst_busy", busy, 0);
`ifdef VRAM_WR_READBACK_EN
    chk("rst_rd_valid", host_rd_valid, 0);
    chk("rst_rd_data", host_rd_data, 0);
`endif
    reset = 1'b1; step();

    // Basic command sequence.
    send(2'd1, 8'h18); send(2'd0, 8'h00); send(2'd3, 8'h01);
    send(2'd2, 8'h05); send(2'd2, 8'h06);
    wait_idle();
    peek("seq_1800", 16'h1800, 8'h05);
    peek("seq_1801", 16'h1801, 8'h06);
    chk("model_ptr_1802", m_ptr, 16'h1802);
    send(2'd2, 8'h07); wait_idle();
    peek("seq_1802", 16'h1802, 8'h07);

    // Backpressure: fill the FIFO with commits blocked.
    wr_allow = 0;
    for (int i = 0; i < 4; i++) send(2'd2, 8'h11 + 8'(i));
    chk("full_ready", host_ready, 0);
    host_cmd = 2'd2; host_data = 8'h15; host_valid = 1;
    step(); step();
    chk("full_hold_ready", host_ready, 0);
    chk("model_occ", mq.size(), 4);
    wr_allow = 1; step();
    chk("ready_after_pop", host_ready, 1);
    step(); host_valid = 0;
    wait_idle();
    chk("busy_after_drain", busy, 0);
    for (int i = 0; i < 5; i++) peek("bp_data", 16'h1803 + 16'(i), 8'h11 + 8'(i));

    // Out-of-range write is dropped; pointer wraps.
    set_addr(16'hFFFF); send(2'd3, 8'h02); send(2'd2, 8'hAA); send(2'd2, 8'h11);
    wait_idle();
    peek("wrap_0001", 16'h0001, 8'h11);
    peek("oob_ffff", 16'hFFFF, 8'h00);
    chk("model_ptr_0003", m_ptr, 16'h0003);

    // Read/write collision at 2ac0.
    send(2'd3, 8'h01); set_addr(16'h2ac0); send(2'd2, 8'h77); set_addr(16'h2ac0);
    wait_idle();
    hpu_addr = 16'h2ac0;
    wr_allow = 0; send(2'd2, 8'h3C); step();
    peek("coll_old", 16'h2ac0, 8'h77);
    wr_allow = 1;
    @(negedge clk); chk("coll_old_edge", hpu_data, 8'h77);
    @(posedge clk); #1; chk("coll_new", hpu_data, 8'h3C);
    #1;

    // Reset with entries queued.
    wr_allow = 0;
    send(2'd2, 8'h01); send(2'd2, 8'h02); send(2'd2, 8'h03);
    reset = 0; #1;
    chk("rst_q_ready", host_ready, 1);
    chk("rst_q_busy", busy, 0);
    step(); reset = 1; wr_allow = 1; step();
    send(2'd2, 8'h5A); send(2'd2, 8'h5B); wait_idle();
    peek("rst_ptr0", 16'h0000, 8'h5A);
    peek("rst_inc1", 16'h0001, 8'h5B);
    peek("rst_keep", 16'h1800, 8'h05);
    chk("rst_dropped", m_known[16'h2ac1], 0);

`ifdef VRAM_WR_READBACK_EN
    set_addr(16'h1800); send(2'd3, 8'h01); wait_idle();
    readback("rb_1800", 8'h05);
    step();
    readback("rb_1801", 8'h06);
    step();
    wr_allow = 0;
    send(2'd2, 8'h99); send(2'd2, 8'h9A);
    host_rd_req = 1; step(); step();
    chk("rb_wait", host_rd_valid, 0);
    wr_allow = 1;
    readback("rb_after_drain", 8'h12);
    step();
    peek("rb_wr_1802", 16'h1802, 8'h99);
`endif

    // Randomized traffic checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] hi_tab [5];
      hi_tab = '{8'h18, 8'h2a, 8'h3f, 8'h40, 8'hff};
      host_valid = ($urandom_range(0, 9) < 7);
      host_cmd   = 2'($urandom_range(0, 3));
      case (host_cmd)
        2'd1: host_data = hi_tab[$urandom_range(0, 4)];
        2'd3: host_data = 8'($urandom_range(0, 3));
        default: host_data = 8'($urandom);
      endcase
      wr_allow = ($urandom_range(0, 3) != 0);
      hpu_addr = {hi_tab[$urandom_range(0, 4)], 8'($urandom)};
`ifdef VRAM_WR_READBACK_EN
      host_rd_req = ($urandom_range(0, 9) == 0);
`endif
      step();
    end
    host_valid = 0; wr_allow = 1;
`ifdef VRAM_WR_READBACK_EN
    host_rd_req = 0;
`endif
    wait_idle();
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
